pixel_read_arbiter: RTL and testbench

// - Shares one read_pixel engine, and the two pyramid BRAMs behind it, between NUM_REQ

---
 rtl/pixel_arb_pkg.sv | 21 ++
 rtl/pixel_read_arbiter_rr_pick.sv | 32 +++
 rtl/pixel_read_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_pixel_read_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_arb_pkg.sv
// Shared types and helpers for the pixel read arbiter.
package pixel_arb_pkg;

  localparam int DEF_DIMENSION = 4;
  localparam int DEF_BIT_DEPTH = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic [$clog2(DEF_DIMENSION)-1:0] coord_t;
  typedef logic signed [DEF_BIT_DEPTH-1:0]  pixel_t;

  function automatic logic coord_in_range(input int unsigned c, input int unsigned dim);
    return (c < dim);
  endfunction

endpackage

// File: rtl/pixel_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr_i+1.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      grant_o,
  output logic               any_o
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Walk NUM_REQ candidates starting after the pointer; first hit wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s   = {1'b0, ptr_i} + (IW+1)'(i);
      idx_s   = (sum_s >= (IW+1)'(NUM_REQ)) ? IW'(sum_s - (IW+1)'(NUM_REQ)) : IW'(sum_s);
      hit_s   = req_i[idx_s] & ~any_o;
      grant_o = hit_s ? idx_s : grant_o;
      any_o   = any_o | hit_s;
    end
  end

endmodule

// File: rtl/pixel_read_arbiter.sv
// Shares one read_pixel engine between NUM_REQ requesters, one access at a time.
// Optional WAIT timeout with resp_err is built only when PIX_ARB_TIMEOUT_EN is defined.
module pixel_read_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DIMENSION      = 4,
  parameter int BIT_DEPTH      = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_in,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ-1:0][$clog2(DIMENSION)-1:0]  req_x,
  input  logic [NUM_REQ-1:0][$clog2(DIMENSION)-1:0]  req_y,
  output logic [NUM_REQ-1:0]                         req_ready,
  output logic [NUM_REQ-1:0]                         resp_valid,
  output logic signed [BIT_DEPTH-1:0]                resp_first,
  output logic signed [BIT_DEPTH-1:0]                resp_second,
  output logic                                       resp_err,
  output logic                                       rd_input_ready,
  output logic [$clog2(DIMENSION)-1:0]               rd_x,
  output logic [$clog2(DIMENSION)-1:0]               rd_y,
  input  logic                                       rd_busy,
  input  logic                                       rd_done,
  input  logic signed [BIT_DEPTH-1:0]                rd_first_data,
  input  logic signed [BIT_DEPTH-1:0]                rd_second_data
);

  localparam int CW = $clog2(DIMENSION);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("pixel_read_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t                      state_q, state_d;
  logic [IW-1:0]               gnt_q, gnt_d, ptr_q, ptr_d;
  logic [CW-1:0]               x_q, x_d, y_q, y_d, rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic [NUM_REQ-1:0]          req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic                        rd_input_ready_q, rd_input_ready_d;
  logic signed [BIT_DEPTH-1:0] first_q, first_d, second_q, second_d;
  logic [IW-1:0]               pick_idx_s;
  logic                        pick_any_s;

`ifdef PIX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx_s),
    .any_o   (pick_any_s)
  );

  // Next-state and registered-output decode for the access sequencer.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    ptr_d            = ptr_q;
    x_d              = x_q;
    y_d              = y_q;
    rd_x_d           = rd_x_q;
    rd_y_d           = rd_y_q;
    first_d          = first_q;
    second_d         = second_q;
    req_ready_d      = '0;
    resp_valid_d     = '0;
    rd_input_ready_d = 1'b0;
`ifdef PIX_ARB_TIMEOUT_EN
    timer_d          = timer_q;
    err_d            = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          gnt_d                   = pick_idx_s;
          x_d                     = req_x[pick_idx_s];
          y_d                     = req_y[pick_idx_s];
          req_ready_d[pick_idx_s] = 1'b1;
          state_d                 = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // Out-of-range coordinates never reach the BRAMs; answer with zero data.
        if (!coord_in_range(32'(x_q), 32'(DIMENSION)) || !coord_in_range(32'(y_q), 32'(DIMENSION))) begin
          first_d  = '0;
          second_d = '0;
`ifdef PIX_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = RESP;
        end else if (rd_busy) begin
          state_d = ISSUE;
        end else begin
          rd_input_ready_d = 1'b1;
          rd_x_d           = x_q;
          rd_y_d           = y_q;
`ifdef PIX_ARB_TIMEOUT_EN
          timer_d          = '0;
`endif
          state_d          = WAIT;
        end
      end
      WAIT: begin
        if (rd_done) begin
          first_d  = rd_first_data;
          second_d = rd_second_data;
`ifdef PIX_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = RESP;
        end
`ifdef PIX_ARB_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          first_d  = '0;
          second_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      RESP: begin
        resp_valid_d[gnt_q] = 1'b1;
        ptr_d               = gnt_q;
        state_d             = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q          <= IDLE;
      gnt_q            <= '0;
      ptr_q            <= IW'(NUM_REQ - 1);
      x_q              <= '0;
      y_q              <= '0;
      rd_x_q           <= '0;
      rd_y_q           <= '0;
      first_q          <= '0;
      second_q         <= '0;
      req_ready_q      <= '0;
      resp_valid_q     <= '0;
      rd_input_ready_q <= 1'b0;
`ifdef PIX_ARB_TIMEOUT_EN
      timer_q          <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      ptr_q            <= ptr_d;
      x_q              <= x_d;
      y_q              <= y_d;
      rd_x_q           <= rd_x_d;
      rd_y_q           <= rd_y_d;
      first_q          <= first_d;
      second_q         <= second_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      rd_input_ready_q <= rd_input_ready_d;
`ifdef PIX_ARB_TIMEOUT_EN
      timer_q          <= timer_d;
      err_q            <= err_d;
`endif
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_first     = first_q;
  assign resp_second    = second_q;
  assign rd_input_ready = rd_input_ready_q;
  assign rd_x           = rd_x_q;
  assign rd_y           = rd_y_q;
`ifdef PIX_ARB_TIMEOUT_EN
  assign resp_err       = err_q;
`else
  assign resp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_read_arbiter.sv
// Directed bench: read_pixel model with pixel(x,y) = x+4y / -(x+4y), three-cycle read latency.
module tb_pixel_read_arbiter;
  import pixel_arb_pkg::*;

  localparam int NR = 2, DIM = 4, BD = 9, CW = 2, RD_LAT = 3;

  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  logic [NR-1:0]          req_valid;
  logic [NR-1:0][CW-1:0]  req_x, req_y;
  logic [NR-1:0]          req_ready, resp_valid;
  logic signed [BD-1:0]   resp_first, resp_second, rd_first_data, rd_second_data;
  logic                   resp_err, rd_input_ready, rd_busy, rd_done;
  logic [CW-1:0]          rd_x, rd_y;
  logic                   force_busy, suppress_done, stray_done;

  logic [NR-1:0]          v5_valid, v5_ready, v5_resp;
  logic [NR-1:0][2:0]     v5_x, v5_y;
  logic signed [BD-1:0]   v5_first, v5_second;
  logic                   v5_err, v5_launch;
  logic [2:0]             v5_rdx, v5_rdy;
  logic signed [BD-1:0]   v5_const = 9'sd77;
  logic                   v5_zero = 1'b0;

  pixel_read_arbiter #(.NUM_REQ(NR), .DIMENSION(DIM), .BIT_DEPTH(BD), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_in(rst_in), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_first(resp_first),
    .resp_second(resp_second), .resp_err(resp_err), .rd_input_ready(rd_input_ready),
    .rd_x(rd_x), .rd_y(rd_y), .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_first_data(rd_first_data), .rd_second_data(rd_second_data));

  pixel_read_arbiter #(.NUM_REQ(NR), .DIMENSION(5), .BIT_DEPTH(BD), .TIMEOUT_CYCLES(16)) dut5 (
    .clk(clk), .rst_in(rst_in), .req_valid(v5_valid), .req_x(v5_x), .req_y(v5_y),
    .req_ready(v5_ready), .resp_valid(v5_resp), .resp_first(v5_first),
    .resp_second(v5_second), .resp_err(v5_err), .rd_input_ready(v5_launch),
    .rd_x(v5_rdx), .rd_y(v5_rdy), .rd_busy(v5_zero), .rd_done(v5_zero),
    .rd_first_data(v5_const), .rd_second_data(v5_const));

  // read_pixel + BRAM model
  logic busy_m, done_m;
  int cnt_m;
  logic [CW-1:0] lx_m, ly_m;
  assign rd_busy = busy_m | force_busy;
  assign rd_done = done_m | stray_done;

  always @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      busy_m <= 1'b0; done_m <= 1'b0; cnt_m <= 0; lx_m <= '0; ly_m <= '0;
      rd_first_data <= '0; rd_second_data <= '0;
    end else begin
      done_m <= 1'b0;
      if (!busy_m && rd_input_ready) begin
        busy_m <= 1'b1; cnt_m <= RD_LAT - 2; lx_m <= rd_x; ly_m <= rd_y;
      end else if (busy_m) begin
        if (cnt_m == 0) begin
          busy_m         <= 1'b0;
          done_m         <= !suppress_done;
          rd_first_data  <= BD'(int'(lx_m) + 4 * int'(ly_m));
          rd_second_data <= BD'(-(int'(lx_m) + 4 * int'(ly_m)));
        end else begin
          cnt_m <= cnt_m - 1;
        end
      end
    end
  end

  int launch_cnt = 0, ready1_cnt = 0, resp1_cnt = 0, launch5_cnt = 0;
  always @(negedge clk) begin
    if (rd_input_ready) launch_cnt <= launch_cnt + 1;
    if (req_ready[1])   ready1_cnt <= ready1_cnt + 1;
    if (resp_valid[1])  resp1_cnt  <= resp1_cnt + 1;
    if (v5_launch)      launch5_cnt <= launch5_cnt + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    return (v == 2'b01) ? 0 : ((v == 2'b10) ? 1 : 9);
  endfunction

  task automatic wait_ready(input string nm, output int g);
    int found = 0;
    g = -1;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin found = 1; g = onehot_idx(req_ready); end
    end
    chk({nm, "_ready_seen"}, found, 1);
  endtask

  task automatic wait_resp(input string nm, output int own, output int lat);
    int found = 0;
    own = -1; lat = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid != '0) begin found = 1; own = onehot_idx(resp_valid); end
    end
    chk({nm, "_resp_seen"}, found, 1);
  endtask

  typedef struct {
    logic [1:0] vmask;
    int x0, y0, x1, y1;
    int eg, ef, es;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int g, own, lat, l0, r1, p1, quiet, ex, ey;
    int found;
    vecs[0] = '{2'b01, 2, 1, 0, 0, 0, 6, -6};
    vecs[1] = '{2'b11, 3, 3, 1, 2, 1, 9, -9};
    vecs[2] = '{2'b11, 3, 3, 1, 2, 0, 15, -15};
    vecs[3] = '{2'b10, 0, 0, 0, 0, 1, 0, 0};
    vecs[4] = '{2'b10, 0, 0, 3, 0, 1, 3, -3};
    vecs[5] = '{2'b01, 0, 3, 0, 0, 0, 12, -12};

    rst_in = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
    force_busy = 1'b0; suppress_done = 1'b0; stray_done = 1'b0;
    v5_valid = '0; v5_x = '0; v5_y = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_launch", rd_input_ready, 0);
    chk("rst_first", resp_first, 0);
    chk("rst_err", resp_err, 0);
    rst_in = 1'b1;

    // Table of single accesses
    for (int r = 0; r < 6; r++) begin
      l0 = launch_cnt;
      req_x[0] = CW'(vecs[r].x0); req_y[0] = CW'(vecs[r].y0);
      req_x[1] = CW'(vecs[r].x1); req_y[1] = CW'(vecs[r].y1);
      req_valid = vecs[r].vmask;
      wait_ready($sformatf("row%0d", r), g);
      chk($sformatf("row%0d_grant", r), g, vecs[r].eg);
      req_valid = '0;
      wait_resp($sformatf("row%0d", r), own, lat);
      ex = (vecs[r].eg == 0) ? vecs[r].x0 : vecs[r].x1;
      ey = (vecs[r].eg == 0) ? vecs[r].y0 : vecs[r].y1;
      chk($sformatf("row%0d_owner", r), own, vecs[r].eg);
      chk($sformatf("row%0d_latency", r), lat, RD_LAT + 3);
      chk($sformatf("row%0d_first", r), resp_first, vecs[r].ef);
      chk($sformatf("row%0d_second", r), resp_second, vecs[r].es);
      chk($sformatf("row%0d_err", r), resp_err, 0);
      @(negedge clk);
      chk($sformatf("row%0d_pulse_end", r), resp_valid, 0);
      chk($sformatf("row%0d_first_hold", r), resp_first, vecs[r].ef);
      chk($sformatf("row%0d_rd_x", r), rd_x, ex);
      chk($sformatf("row%0d_rd_y", r), rd_y, ey);
      chk($sformatf("row%0d_launches", r), launch_cnt - l0, 1);
    end

    // Stray rd_done while idle
    l0 = launch_cnt; r1 = resp1_cnt; quiet = 0;
    stray_done = 1'b1; @(negedge clk); stray_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid != '0 || req_ready != '0) quiet++;
    end
    chk("stray_no_launch", launch_cnt - l0, 0);
    chk("stray_no_activity", quiet, 0);

    // Cancel: req1 raised and dropped while req0 is being served
    r1 = resp1_cnt; p1 = ready1_cnt;
    req_x[0] = 2'd1; req_y[0] = 2'd1; req_valid = 2'b01;
    wait_ready("cancel", g);
    chk("cancel_grant", g, 0);
    req_valid = 2'b10; req_x[1] = 2'd0; req_y[1] = 2'd1;
    @(negedge clk); @(negedge clk);
    req_valid = '0;
    wait_resp("cancel", own, lat);
    chk("cancel_owner", own, 0);
    chk("cancel_first", resp_first, 5);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("cancel_no_ready1", ready1_cnt - p1, 0);
    chk("cancel_no_resp1", resp1_cnt - r1, 0);

    // Busy hold in ISSUE
    l0 = launch_cnt;
    force_busy = 1'b1;
    req_x[1] = 2'd3; req_y[1] = 2'd2; req_valid = 2'b10;
    wait_ready("busy", g);
    chk("busy_grant", g, 1);
    req_valid = '0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("busy_no_launch", launch_cnt - l0, 0);
    force_busy = 1'b0;
    wait_resp("busy", own, lat);
    chk("busy_owner", own, 1);
    chk("busy_first", resp_first, 11);
    chk("busy_second", resp_second, -11);
    chk("busy_launches", launch_cnt - l0, 1);

`ifdef PIX_ARB_TIMEOUT_EN
    suppress_done = 1'b1;
    req_x[0] = 2'd3; req_y[0] = 2'd1; req_valid = 2'b01;
    wait_ready("tmo", g);
    req_valid = '0;
    wait_resp("tmo", own, lat);
    chk("tmo_owner", own, 0);
    chk("tmo_latency", lat, 18);
    chk("tmo_first", resp_first, 0);
    chk("tmo_second", resp_second, 0);
    chk("tmo_err", resp_err, 1);
    suppress_done = 1'b0;
    @(negedge clk); @(negedge clk);
`endif

    // Out-of-range coordinates on the DIMENSION=5 instance
    for (int k = 0; k < 2; k++) begin
      l0 = launch5_cnt; found = 0; g = -1; own = -1;
      v5_x[k] = (k == 0) ? 3'd5 : 3'd1;
      v5_y[k] = (k == 0) ? 3'd0 : 3'd7;
      v5_valid = (k == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < 20 && found == 0; i++) begin
        @(negedge clk);
        if (v5_ready != '0) begin found = 1; g = onehot_idx(v5_ready); end
      end
      v5_valid = '0;
      chk($sformatf("range%0d_grant", k), g, k);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
        @(negedge clk);
        if (v5_resp != '0) begin found = 1; own = onehot_idx(v5_resp); end
      end
      chk($sformatf("range%0d_owner", k), own, k);
      chk($sformatf("range%0d_first", k), v5_first, 0);
      chk($sformatf("range%0d_no_launch", k), launch5_cnt - l0, 0);
    end

    // Reset in the middle of WAIT
    req_x[0] = 2'd2; req_y[0] = 2'd2; req_valid = 2'b01;
    wait_ready("midrst", g);
    req_valid = '0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (rd_input_ready) found = 1;
    end
    chk("midrst_launch_seen", found, 1);
    @(negedge clk);
    rst_in = 1'b0;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_first", resp_first, 0);
    chk("midrst_second", resp_second, 0);
    chk("midrst_rd_x", rd_x, 0);
    chk("midrst_rd_y", rd_y, 0);
    chk("midrst_launch", rd_input_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_in = 1'b1;

    // Contention: both held high for four accesses, req0 first after reset
    req_x[0] = 2'd1; req_y[0] = 2'd0; req_x[1] = 2'd2; req_y[1] = 2'd2;
    req_valid = 2'b11;
    for (int a = 0; a < 4; a++) begin
      wait_ready($sformatf("cont%0d", a), g);
      chk($sformatf("cont%0d_grant", a), g, a % 2);
      wait_resp($sformatf("cont%0d", a), own, lat);
      if (a == 3) req_valid = '0;
      chk($sformatf("cont%0d_owner", a), own, a % 2);
      chk($sformatf("cont%0d_first", a), resp_first, (a % 2 == 0) ? 1 : 10);
      chk($sformatf("cont%0d_second", a), resp_second, (a % 2 == 0) ? -1 : -10);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
